// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, branch flush and registered bypass selects
// for a 5-stage pipeline. A shadow of the X and M destinations is kept in
// step with the real pipeline and frozen whenever data memory is busy.
module hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  d_valid,
  input  logic [REG_ADDR_W-1:0] d_rs,
  input  logic [REG_ADDR_W-1:0] d_rt,
  input  logic                  d_uses_rs,
  input  logic                  d_uses_rt,
  input  logic [REG_ADDR_W-1:0] d_rd,
  input  logic                  d_rwe,
  input  logic                  d_is_load,
  input  logic                  d_is_store,
  input  logic                  do_branch,
  input  logic                  mem_busy,
  output logic                  issue,
  output logic                  stall,
  output logic                  flush_fd,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  fwd_wm,
  output logic [CNT_W-1:0]      stall_count
);

  // Producer view of one in-flight instruction.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rwe;
  } shadow_t;

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_MX = 2'b01;
  localparam logic [1:0] SEL_WX = 2'b10;

  // The W-stage entry never selects a bypass (the register file writes in W
  // before D reads), so only the X and M producers are tracked. The load
  // flag matters only while the instruction sits in X.
  shadow_t          x_q, x_d;
  shadow_t          m_q;
  logic             x_ld_q, x_ld_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic             fwd_wm_q, fwd_wm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  // True when stage s will write register r; r0 is never a real producer.
  function automatic logic prod(input shadow_t s, input logic [REG_ADDR_W-1:0] r);
    return s.valid & s.rwe & (s.rd == r) & (r != '0);
  endfunction

  // Youngest producer wins: MX before WX.
  function automatic logic [1:0] pick(input logic hit_x, input logic hit_m);
    if (hit_x)      return SEL_MX;
    else if (hit_m) return SEL_WX;
    else            return SEL_RF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Same-cycle hazard detection; store data (rt) is exempt because WM covers it.
  always_comb begin
    lu       = d_valid & x_ld_q &
               ((d_uses_rs & prod(x_q, d_rs)) |
                (d_uses_rt & prod(x_q, d_rt) & ~d_is_store));
    stall    = lu & ~do_branch & reset_n;
    flush_fd = do_branch & reset_n;
    issue    = d_valid & ~lu & ~do_branch & ~mem_busy & reset_n;
  end

  // Next shadow entry and the selects that travel with it into D/X.
  always_comb begin
    x_d      = '0;
    x_ld_d   = 1'b0;
    fwd_a_d  = SEL_RF;
    fwd_b_d  = SEL_RF;
    fwd_wm_d = 1'b0;
    cnt_d    = cnt_q;
    if (issue) begin
      x_d.valid = 1'b1;
      x_d.rd    = d_rd;
      x_d.rwe   = d_rwe;
      x_ld_d    = d_is_load;
      fwd_wm_d  = d_is_store & x_ld_q & prod(x_q, d_rt);
      if (d_uses_rs)
        fwd_a_d = pick(prod(x_q, d_rs), prod(m_q, d_rs));
      if (d_uses_rt && !fwd_wm_d)
        fwd_b_d = pick(prod(x_q, d_rt), prod(m_q, d_rt));
    end
    if (stall)
      cnt_d = sat_inc(cnt_q);
  end

  // Advance the shadow and selects unless memory is busy; reset clears all.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_q      <= '0;
      x_ld_q   <= 1'b0;
      m_q      <= '0;
      fwd_a_q  <= SEL_RF;
      fwd_b_q  <= SEL_RF;
      fwd_wm_q <= 1'b0;
      cnt_q    <= '0;
    end else if (!mem_busy) begin
      x_q      <= x_d;
      x_ld_q   <= x_ld_d;
      m_q      <= x_q;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      fwd_wm_q <= fwd_wm_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign fwd_wm      = fwd_wm_q;
  assign stall_count = cnt_q;

endmodule
